// File: rtl/water_level_pkg.sv
// Shared types and constants for the water level sensing and pump control blocks.
package water_level_pkg;

  localparam int LEVEL_W = 3;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 3'b111;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    MONITOR  = 2'd1,
    FILL     = 2'd2,
    FAULT    = 2'd3
  } pump_state_e;

endpackage

// File: rtl/level_debouncer.sv
// Accepts a new level only after it has been sampled STABLE_CYCLES times in a row.
module level_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int W             = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] level_in,
  output logic [W-1:0] level_stable,
  output logic         rise
);

  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

  logic [W-1:0]     in_q;
  logic [RUN_W-1:0] run;
  logic             accept;

  // rise is asserted on the very edge at which level_stable moves upward
  assign accept = (run == RUN_MAX) && (in_q != level_stable);
  assign rise   = accept && (in_q > level_stable);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q         <= '0;
      run          <= '0;
      level_stable <= '0;
    end else begin
      in_q <= level_in;
      if (level_in != in_q) begin
        run <= RUN_W'(1);
      end else if (run != RUN_MAX) begin
        run <= run + RUN_W'(1);
      end
      if (accept) begin
        level_stable <= in_q;
      end
    end
  end

endmodule

// File: rtl/water_pump_controller.sv
// Fill-pump controller: debounced level, hysteresis between LOW/HIGH, stall fault, overflow alarm.
module water_pump_controller
  import water_level_pkg::*;
#(
  parameter int                  STABLE_CYCLES = 4,
  parameter logic [LEVEL_W-1:0]  LOW_LEVEL     = 3'd1,
  parameter logic [LEVEL_W-1:0]  HIGH_LEVEL    = 3'd6,
  parameter int                  FILL_TIMEOUT  = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LEVEL_W-1:0] level_in,
  input  logic               enable,
  input  logic               fault_clear,
  output logic               pump_on,
  output logic [LEVEL_W-1:0] level_stable,
  output logic               overflow_alarm,
  output logic               fault,
  output logic [1:0]         state
);

  localparam int TIMER_W = $clog2(FILL_TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(FILL_TIMEOUT - 1);

  pump_state_e        state_q, state_d;
  logic [TIMER_W-1:0] stall_timer;
  logic               level_rise;

  level_debouncer #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .W             (LEVEL_W)
  ) u_debouncer (
    .clk          (clk),
    .rst          (rst),
    .level_in     (level_in),
    .level_stable (level_stable),
    .rise         (level_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DISABLED;
    end else begin
      state_q <= state_d;
    end
  end

  // enable has top priority in FILL, then reaching HIGH, then the stall timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      DISABLED: begin
        if (enable) state_d = MONITOR;
      end
      MONITOR: begin
        if (!enable)                       state_d = DISABLED;
        else if (level_stable <= LOW_LEVEL) state_d = FILL;
      end
      FILL: begin
        if (!enable)                         state_d = DISABLED;
        else if (level_stable >= HIGH_LEVEL) state_d = MONITOR;
        else if (stall_timer == TIMER_LAST)  state_d = FAULT;
      end
      FAULT: begin
        if (fault_clear) state_d = DISABLED;
      end
      default: state_d = DISABLED;
    endcase
  end

  // Restarted when FILL is entered and whenever the accepted level rises during FILL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_timer <= '0;
    end else if (state_d == FILL && (state_q != FILL || level_rise)) begin
      stall_timer <= '0;
    end else if (state_q == FILL) begin
      stall_timer <= stall_timer + TIMER_W'(1);
    end
  end

  assign pump_on        = (state_q == FILL);
  assign fault          = (state_q == FAULT);
  assign state          = state_q;
  assign overflow_alarm = (level_stable == LEVEL_MAX);

endmodule

// File: tb/tb_water_pump_controller.sv
// Randomized scoreboard bench for water_pump_controller against a sample-history reference model.
module tb_water_pump_controller;

  localparam int S_CYC = 4;
  localparam int LOW   = 1;
  localparam int HIGH  = 6;
  localparam int TO    = 20;

  localparam int M_DIS  = 0;
  localparam int M_MON  = 1;
  localparam int M_FILL = 2;
  localparam int M_FLT  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] level_in;
  logic       enable;
  logic       fault_clear;
  logic       pump_on;
  logic [2:0] level_stable;
  logic       overflow_alarm;
  logic       fault;
  logic [1:0] state;

  typedef struct {
    int ls;
    int st;
  } exp_t;

  exp_t exp_q[$];
  int   hist[$];
  int   m_ls, m_st, m_mark, cyc;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  water_pump_controller #(
    .STABLE_CYCLES (S_CYC),
    .LOW_LEVEL     (3'(LOW)),
    .HIGH_LEVEL    (3'(HIGH)),
    .FILL_TIMEOUT  (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .level_in       (level_in),
    .enable         (enable),
    .fault_clear    (fault_clear),
    .pump_on        (pump_on),
    .level_stable   (level_stable),
    .overflow_alarm (overflow_alarm),
    .fault          (fault),
    .state          (state)
  );

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic modelReset();
    hist.delete();
    m_ls   = 0;
    m_st   = M_DIS;
    m_mark = 0;
    cyc    = 0;
  endtask

  // A level is accepted once the last S_CYC samples since reset all agree and differ from the current one
  task automatic modelStep(input int lvl, input bit en, input bit clr);
    int  new_ls = m_ls;
    int  nst    = m_st;
    int  timer  = cyc - m_mark;
    bit  same   = 1'b1;
    if (hist.size() == S_CYC) begin
      foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
      if (same && hist[0] != m_ls) new_ls = hist[0];
    end
    case (m_st)
      M_DIS:  if (en) nst = M_MON;
      M_MON:  if (!en) nst = M_DIS; else if (m_ls <= LOW) nst = M_FILL;
      M_FILL: if (!en) nst = M_DIS; else if (m_ls >= HIGH) nst = M_MON;
              else if (timer == TO - 1) nst = M_FLT;
      default: if (clr) nst = M_DIS;
    endcase
    if (nst == M_FILL && (m_st != M_FILL || new_ls > m_ls)) m_mark = cyc + 1;
    cyc++;
    hist.push_back(lvl);
    if (hist.size() > S_CYC) void'(hist.pop_front());
    m_ls = new_ls;
    m_st = nst;
    exp_q.push_back('{ls: m_ls, st: m_st});
  endtask

  task automatic applyStimulus(input int lvl, input bit en, input bit clr);
    @(negedge clk);
    level_in    = 3'(lvl);
    enable      = en;
    fault_clear = clr;
    modelStep(lvl, en, clr);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_pump_on"}, pump_on, 0);
    checkOutput({tag, "_level_stable"}, level_stable, 0);
    checkOutput({tag, "_overflow"}, overflow_alarm, 0);
    checkOutput({tag, "_fault"}, fault, 0);
    checkOutput({tag, "_state"}, state, M_DIS);
  endtask

  task automatic randomRun(input int n_cycles);
    int done = 0;
    while (done < n_cycles) begin
      int pick = $urandom_range(0, 9);
      int lvl  = (pick < 4) ? $urandom_range(0, 2) :
                 (pick < 7) ? $urandom_range(3, 5) : $urandom_range(6, 7);
      int hold = $urandom_range(1, 25);
      for (int k = 0; k < hold; k++) begin
        applyStimulus(lvl, $urandom_range(0, 39) != 0, $urandom_range(0, 29) == 0);
      end
      done += hold;
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput("level_stable", level_stable, e.ls);
      checkOutput("state", state, e.st);
      checkOutput("pump_on", pump_on, int'(e.st == M_FILL));
      checkOutput("fault", fault, int'(e.st == M_FLT));
      checkOutput("overflow_alarm", overflow_alarm, int'(e.ls == 7));
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    rst         = 1'b1;
    level_in    = 3'd0;
    enable      = 1'b1;
    fault_clear = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    #1 rst = 1'b0;
    #1 checkAllZero("release");

    // Stall: hold level 0 through the timeout, then clear the fault
    for (int k = 0; k < 26; k++) applyStimulus(0, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0);
    applyStimulus(0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) applyStimulus(0, 1'b1, 1'b0);

    // Hysteresis staircase, then drop back, then glitch and overflow
    for (int lv = 2; lv <= 6; lv++)
      for (int k = 0; k < 10; k++) applyStimulus(lv, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) applyStimulus(3, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) applyStimulus(1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(7, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) applyStimulus(1, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) applyStimulus(7, 1'b1, 1'b0);

    randomRun(2500);

    // Drive into FILL, then reset asynchronously between edges
    applyStimulus(0, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) applyStimulus(0, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("pre_reset_pump_on", pump_on, int'(m_st == M_FILL));
    rst = 1'b1;
    #1;
    checkAllZero("async_reset");
    modelReset();
    @(posedge clk);
    #3 rst = 1'b0;

    randomRun(1500);

    @(posedge clk);
    #2;
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/water_pump_controller.md
Name: water_pump_controller

Overview:
- Downstream consumer of the 3-bit water level code produced by the sensor encoder.
- Debounces the level code and runs a fill-pump state machine with hysteresis between a low and a high threshold.
- Detects a stalled fill (pump on, level not rising) and reports a latched fault.
- Raises an overflow alarm at the top level.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a level change is accepted (>=1).
- LOW_LEVEL, 3'd1: pump starts when the accepted level is <= this value.
- HIGH_LEVEL, 3'd6: pump stops when the accepted level is >= this value. Must satisfy HIGH_LEVEL > LOW_LEVEL.
- FILL_TIMEOUT, 1000: cycles in FILL with no accepted level increase before FAULT (>=2).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- level_in  in  3  level code from the sensor encoder, asynchronous to nothing, sampled every clk.
- enable  in  1  1 = controller may run the pump.
- fault_clear  in  1  single-cycle pulse that exits FAULT.
- pump_on  out  1  pump drive.
- level_stable  out  3  debounced, accepted level.
- overflow_alarm  out  1  accepted level == 3'b111.
- fault  out  1  1 while in FAULT.
- state  out  2  current FSM state, for debug.

Behaviour:
- Reset is asynchronous, active-high. All outputs are 0 during and after reset: level_stable=0, pump_on=0, overflow_alarm=0, fault=0, state=DISABLED.
- Input register: level_in is captured into in_q on every edge.
- Debounce:
  - A run counter counts consecutive edges on which in_q is unchanged. A change in in_q restarts the run at 1.
  - When the run reaches STABLE_CYCLES and in_q differs from level_stable, level_stable takes in_q on that edge.
  - Total latency: level_stable updates STABLE_CYCLES+1 edges after level_in changes.
  - Glitches shorter than STABLE_CYCLES samples never reach level_stable.
  - The run counter saturates.
- FSM states (encoding in package): DISABLED=0, MONITOR=1, FILL=2, FAULT=3. Transitions are evaluated on the registered level_stable.
- DISABLED:
  - enable=1 -> MONITOR.
- MONITOR:
  - enable=0 -> DISABLED.
  - else level_stable <= LOW_LEVEL -> FILL.
- FILL (priority order):
  1. enable=0 -> DISABLED.
  2. level_stable >= HIGH_LEVEL -> MONITOR.
  3. Stall timer == FILL_TIMEOUT-1 -> FAULT.
- FAULT:
  - Stays in FAULT regardless of enable or level.
  - fault_clear=1 -> DISABLED.
- Stall timer:
  - Cleared on entry to FILL and on any edge where level_stable increases while in FILL.
  - Otherwise increments by 1 each cycle in FILL.
  - Width is $clog2(FILL_TIMEOUT).
  - A level decrease does not clear it.
- Outputs:
  - pump_on = (state==FILL); fault = (state==FAULT). Both are decoded from the state register, so they are glitch-free and change on the same edge as state.
  - overflow_alarm = (level_stable==3'b111). It is independent of state and is also asserted in DISABLED and FAULT.
- Simultaneous events:
  - enable=0 and a threshold crossing on the same edge: enable wins.
  - HIGH reached on the same edge as the timeout: go to MONITOR, not FAULT.
  - fault_clear outside FAULT has no effect.
- Reset mid-fill: pump_on drops immediately (asynchronously) and the debounce history is lost. After release, level is re-accepted from 0, so MONITOR enters FILL until the real level is accepted.

Decomposition:
- Package water_level_pkg:
  - FSM state typedef/localparams (DISABLED/MONITOR/FILL/FAULT).
  - LEVEL_W=3.
  - LEVEL_MAX=3'b111.
- One natural sub-module, level_debouncer (params STABLE_CYCLES, W):
  - Contains the input register, run counter and level_stable register.
  - Reusable for the other sensor encoders.
- The FSM, stall timer and output decode stay in the top module.

Test Plan (STABLE_CYCLES=4, LOW_LEVEL=1, HIGH_LEVEL=6, FILL_TIMEOUT=20):
- Reset/enable: deassert rst with level_in=0, enable=1 -> all outputs 0 at release; state DISABLED->MONITOR->FILL on successive edges; pump_on=1 two edges after release.
- Debounce: level 0->5 held -> level_stable=5 exactly 5 edges later. A 3-cycle pulse to 7 -> level_stable unchanged and overflow_alarm never asserts.
- Hysteresis: in FILL, step level 2,3,4,5 every 10 cycles -> pump stays on. Step to 6 -> MONITOR, pump_on=0. Drop to 3 -> still off. Drop to 1 -> FILL again.
- Stall fault: in FILL hold level=2 -> FAULT exactly 20 cycles after FILL entry, pump_on=0, fault=1. Toggle enable -> stays FAULT. fault_clear pulse -> DISABLED, then MONITOR.
- Priority: enable=0 on the same edge level_stable reaches 6 -> DISABLED. Level reaches 6 on the timeout edge -> MONITOR, fault=0.
- Overflow/reset: level=7 held -> overflow_alarm=1 after 5 edges, pump off. Assert rst mid-FILL -> pump_on=0 and level_stable=0 without a clock edge.
